tuner_seq_ctrl: RTL and testbench
=================================

# tuner_seq_ctrl

Sequencing controller for one `tuner_phy` instance. It drives the search handshake and captures the peak table. It selects one peak by index, programs the lock peak configuration, and starts lock. While locked it services lock interrupts, resuming in place up to a configured budget and then falling back to a full re-search. It sits between the host/CSR layer and the `tuner_phy` search/lock interfaces, as their consumer.

## Interface
- `DAC_WIDTH`, 8: ring tune code width.
- `ADC_WIDTH`, 8: power code width.
- `NUM_TARGET`, 8: peak table depth.
- `TMO_WIDTH`, 16: search watchdog counter width.
- `i_clk` in 1: the single clock.
- `i_rst_n` in 1: reset, synchronous, active-low.
- `i_en` in 1: host start level.
- `i_cfg_target_idx` in $clog2(NUM_TARGET): index of the peak to lock.
- `i_cfg_max_relock` in 4: count of in-place resumes allowed before a re-search.
- `i_cfg_search_tmo` in TMO_WIDTH: watchdog cycle budget in SEARCH_WAIT; 0 disables it.
- `o_search_trig_val` out 1 / `i_search_trig_rdy` in 1: search trigger handshake.
- `i_search_done_val` in 1 / `o_search_done_rdy` out 1: peak result handshake.
- `i_peak_tune_codes` in DAC_WIDTH x NUM_TARGET: peak tune codes.
- `i_peak_pwr_codes` in ADC_WIDTH x NUM_TARGET: peak power codes.
- `i_num_peaks` in $clog2(NUM_TARGET)+1: number of valid peaks.
- `o_lock_trig_val` out 1 / `i_lock_trig_rdy` in 1: lock trigger handshake.
- `i_lock_intr_val` in 1 / `o_lock_intr_rdy` out 1: lock-loss interrupt handshake.
- `o_lock_resume_val` out 1 / `i_lock_resume_rdy` in 1: lock resume handshake.
- `o_cfg_ring_tune_peak` out DAC_WIDTH: lock tune code, to the phy.
- `o_cfg_pwr_peak` out ADC_WIDTH: lock power code, to the phy.
- `o_state` out 3: FSM state monitor.
- `o_locked` out 1: high in LOCKED only.
- `o_err` out 2: 0 none, 1 no peaks, 2 index out of range, 3 search timeout.
- `o_relock_cnt` out 4: resumes since the last search.
- `o_search_cnt` out 8: searches since reset, saturating at 255.

## Operation
- All outputs are registered.
- Every handshake transfers on a cycle where val & rdy.
- FSM states, with `o_state` encoding:
  - IDLE=0: on `i_en`=1, go to S_TRIG.
  - S_TRIG=1: assert `o_search_trig_val` until the transfer; then go to S_WAIT and clear the watchdog.
    - `o_relock_cnt` clears on entering S_TRIG.
    - `o_search_cnt` increments on each S_TRIG transfer.
  - S_WAIT=2: assert `o_search_done_rdy`.
    - On transfer, capture the entry at `i_cfg_target_idx` from the peak arrays, plus `i_num_peaks`, then go to SELECT.
    - The watchdog increments each cycle. If `i_cfg_search_tmo`≠0 and the count reaches `i_cfg_search_tmo` with no transfer, go to ERR with code 3.
  - SELECT=3, one cycle:
    - `num_peaks`==0: go to ERR with code 1.
    - Else `target_idx` ≥ `num_peaks`: go to ERR with code 2.
    - Else load `o_cfg_ring_tune_peak` and `o_cfg_pwr_peak` from the captured entry and go to L_TRIG.
  - L_TRIG=4: assert `o_lock_trig_val` until the transfer; then go to LOCKED.
  - LOCKED=5: `o_locked`=1 and `o_lock_intr_rdy`=1. On an interrupt transfer:
    - If `o_relock_cnt` < `i_cfg_max_relock`: increment `o_relock_cnt` and go to RESUME.
    - Else go to S_TRIG for a full re-search.
  - RESUME=6: assert `o_lock_resume_val` until the transfer; then go to LOCKED. The cfg outputs are unchanged.
  - ERR=7: hold `o_err`. When `i_en`=0, clear `o_err` and go to IDLE.
- `i_en` is sampled only in IDLE and ERR. Once started, the sequence runs until ERR or reset.
- A val, once raised, stays high until its transfer.
- At most one of the three val outputs and two rdy outputs is high in any cycle.
- `i_cfg_*` inputs are sampled at point of use:
  - `target_idx` in S_WAIT/SELECT.
  - `max_relock` in LOCKED.
  - `search_tmo` each S_WAIT cycle.
- `i_cfg_max_relock`=0 makes every interrupt trigger a re-search.
- If an interrupt arrives in the same cycle LOCKED is entered, it is accepted that cycle.

## Timing
- Reset (`i_rst_n`=0 at an `i_clk` edge):
  - State is IDLE.
  - All val/rdy outputs, `o_locked`, `o_err`, `o_relock_cnt`, `o_search_cnt` and both cfg outputs are 0.
  - Reset mid-handshake drops val the next cycle.
- IDLE with `i_en`=1 at edge N: `o_search_trig_val`=1 from cycle N+1.
- Search transfer at cycle N: `o_search_done_rdy`=1 from N+1.
- Done transfer at cycle M:
  - SELECT during M+1.
  - cfg outputs valid and `o_lock_trig_val`=1 from M+2.
- Lock trigger transfer at cycle K: `o_locked`=1 from K+1.
- Interrupt transfer at cycle J: `o_locked`=0 from J+1, with `o_lock_resume_val` or `o_search_trig_val` =1 from J+1.
- Timeout: exactly `i_cfg_search_tmo` S_WAIT cycles without done_val, then ERR on the next cycle.

## Test plan
- 3 peaks (tune 40/90/200), idx=1 → `o_cfg_ring_tune_peak`=90, lock trigger issued 2 cycles after done, `o_locked`=1.
- `i_num_peaks`=0 → ERR with `o_err`=1; drop `i_en` → IDLE with `o_err`=0; raise `i_en` → new search, `o_search_cnt`=2.
- idx=5 with 3 peaks → `o_err`=2, and no lock trigger is ever issued.
- `max_relock`=2, four interrupts:
  - Two resumes with `o_relock_cnt`=1 then 2.
  - Third interrupt → re-search with `o_relock_cnt`=0.
  - Fourth interrupt (after relock) → resume.
- `i_cfg_search_tmo`=10, done_val never asserted → `o_err`=3 after 10 S_WAIT cycles; `i_cfg_search_tmo`=0 → never times out.
- rdy held low for 5 cycles on each handshake → val held stable with a single transfer each; `i_rst_n`=0 mid-L_TRIG → all outputs 0 the next cycle.

Source files
------------

// File: rtl/tuner_seq_ctrl_if.sv
// Search/lock handshake bundle between tuner_seq_ctrl and one tuner_phy.
// The master side is the sequencer, the slave side is the phy.
interface tuner_seq_ctrl_if #(
   parameter int DAC_WIDTH  = 8,
   parameter int ADC_WIDTH  = 8,
   parameter int NUM_TARGET = 8
);
   logic o_search_trig_val;
   logic i_search_trig_rdy;
   logic i_search_done_val;
   logic o_search_done_rdy;
   logic [NUM_TARGET-1:0][DAC_WIDTH-1:0] i_peak_tune_codes;
   logic [NUM_TARGET-1:0][ADC_WIDTH-1:0] i_peak_pwr_codes;
   logic [$clog2(NUM_TARGET):0] i_num_peaks;
   logic o_lock_trig_val;
   logic i_lock_trig_rdy;
   logic i_lock_intr_val;
   logic o_lock_intr_rdy;
   logic o_lock_resume_val;
   logic i_lock_resume_rdy;

   modport master (
      output o_search_trig_val,
      input  i_search_trig_rdy,
      input  i_search_done_val,
      output o_search_done_rdy,
      input  i_peak_tune_codes,
      input  i_peak_pwr_codes,
      input  i_num_peaks,
      output o_lock_trig_val,
      input  i_lock_trig_rdy,
      input  i_lock_intr_val,
      output o_lock_intr_rdy,
      output o_lock_resume_val,
      input  i_lock_resume_rdy
   );

   modport slave (
      input  o_search_trig_val,
      output i_search_trig_rdy,
      output i_search_done_val,
      input  o_search_done_rdy,
      output i_peak_tune_codes,
      output i_peak_pwr_codes,
      output i_num_peaks,
      input  o_lock_trig_val,
      output i_lock_trig_rdy,
      output i_lock_intr_val,
      input  o_lock_intr_rdy,
      input  o_lock_resume_val,
      output i_lock_resume_rdy
   );
endinterface

// File: rtl/tuner_seq_ctrl.sv
// Search / select / lock sequencer for a single tuner_phy.
// Handshake outputs are pure decodes of the state register.
module tuner_seq_ctrl #(
   parameter int DAC_WIDTH  = 8,
   parameter int ADC_WIDTH  = 8,
   parameter int NUM_TARGET = 8,
   parameter int TMO_WIDTH  = 16
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_en,
   input  logic [$clog2(NUM_TARGET)-1:0] i_cfg_target_idx,
   input  logic [3:0]                    i_cfg_max_relock,
   input  logic [TMO_WIDTH-1:0]          i_cfg_search_tmo,
   tuner_seq_ctrl_if.master              bus,
   output logic [DAC_WIDTH-1:0]          o_cfg_ring_tune_peak,
   output logic [ADC_WIDTH-1:0]          o_cfg_pwr_peak,
   output logic [2:0]                    o_state,
   output logic                          o_locked,
   output logic [1:0]                    o_err,
   output logic [3:0]                    o_relock_cnt,
   output logic [7:0]                    o_search_cnt
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      S_TRIG  = 3'd1,
      S_WAIT  = 3'd2,
      SELECT  = 3'd3,
      L_TRIG  = 3'd4,
      LOCKED  = 3'd5,
      RESUME  = 3'd6,
      ERR     = 3'd7
   } state_t;

   state_t state, state_d;
   logic [1:0] err_q, err_d;
   logic [3:0] relock_q;
   logic [7:0] search_q;
   logic [TMO_WIDTH-1:0] wdog_q, wdog_inc;
   logic [DAC_WIDTH-1:0] cap_tune, tune_q;
   logic [ADC_WIDTH-1:0] cap_pwr, pwr_q;
   logic [$clog2(NUM_TARGET):0] cap_num;
   logic trig_xfer, done_xfer, lock_xfer, intr_xfer, res_xfer;

   assign bus.o_search_trig_val = (state == S_TRIG);
   assign bus.o_search_done_rdy = (state == S_WAIT);
   assign bus.o_lock_trig_val   = (state == L_TRIG);
   assign bus.o_lock_intr_rdy   = (state == LOCKED);
   assign bus.o_lock_resume_val = (state == RESUME);

   assign trig_xfer = bus.o_search_trig_val & bus.i_search_trig_rdy;
   assign done_xfer = bus.o_search_done_rdy & bus.i_search_done_val;
   assign lock_xfer = bus.o_lock_trig_val & bus.i_lock_trig_rdy;
   assign intr_xfer = bus.o_lock_intr_rdy & bus.i_lock_intr_val;
   assign res_xfer  = bus.o_lock_resume_val & bus.i_lock_resume_rdy;
   assign wdog_inc  = wdog_q + TMO_WIDTH'(1);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) state <= IDLE;
      else          state <= state_d;
   end

   always_comb begin
      state_d = state;
      err_d   = err_q;
      unique case (state)
         IDLE:   if (i_en) state_d = S_TRIG;
         S_TRIG: if (trig_xfer) state_d = S_WAIT;
         S_WAIT: begin
            if (done_xfer) begin
               state_d = SELECT;
            end else if (i_cfg_search_tmo != '0 &&
                         wdog_inc >= i_cfg_search_tmo) begin
               state_d = ERR;
               err_d   = 2'd3;
            end
         end
         SELECT: begin
            if (cap_num == '0) begin
               state_d = ERR;
               err_d   = 2'd1;
            end else if ({1'b0, i_cfg_target_idx} >= cap_num) begin
               state_d = ERR;
               err_d   = 2'd2;
            end else begin
               state_d = L_TRIG;
            end
         end
         L_TRIG: if (lock_xfer) state_d = LOCKED;
         LOCKED: begin
            if (intr_xfer) begin
               if (relock_q < i_cfg_max_relock) state_d = RESUME;
               else                             state_d = S_TRIG;
            end
         end
         RESUME: if (res_xfer) state_d = LOCKED;
         ERR: begin
            if (!i_en) begin
               state_d = IDLE;
               err_d   = 2'd0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         err_q    <= '0;
         relock_q <= '0;
         search_q <= '0;
         wdog_q   <= '0;
         cap_tune <= '0;
         cap_pwr  <= '0;
         cap_num  <= '0;
         tune_q   <= '0;
         pwr_q    <= '0;
      end else begin
         err_q <= err_d;
         if (state_d == S_TRIG && state != S_TRIG)
            relock_q <= '0;
         else if (state == LOCKED && state_d == RESUME)
            relock_q <= relock_q + 4'd1;
         if (trig_xfer && search_q != 8'hff)
            search_q <= search_q + 8'd1;
         if (trig_xfer)
            wdog_q <= '0;
         else if (state == S_WAIT)
            wdog_q <= wdog_inc;
         if (done_xfer) begin
            cap_tune <= bus.i_peak_tune_codes[i_cfg_target_idx];
            cap_pwr  <= bus.i_peak_pwr_codes[i_cfg_target_idx];
            cap_num  <= bus.i_num_peaks;
         end
         // cfg only moves on a fresh select; resumes keep the old peak
         if (state == SELECT && state_d == L_TRIG) begin
            tune_q <= cap_tune;
            pwr_q  <= cap_pwr;
         end
      end
   end

   assign o_state              = state;
   assign o_locked             = (state == LOCKED);
   assign o_err                = err_q;
   assign o_relock_cnt         = relock_q;
   assign o_search_cnt         = search_q;
   assign o_cfg_ring_tune_peak = tune_q;
   assign o_cfg_pwr_peak       = pwr_q;

endmodule

// File: tb/tb_tuner_seq_ctrl.sv
// Randomized self-checking bench for tuner_seq_ctrl.
// The bench plays the tuner_phy side of every handshake.
module tb_tuner_seq_ctrl;
   localparam int DW = 8;
   localparam int AW = 8;
   localparam int NT = 8;
   localparam int TW = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic          en;
   logic [2:0]    idx;
   logic [3:0]    max_relock;
   logic [TW-1:0] tmo;
   logic [DW-1:0] tune_out;
   logic [AW-1:0] pwr_out;
   logic [2:0]    st;
   logic          locked;
   logic [1:0]    err;
   logic [3:0]    relock;
   logic [7:0]    scnt;

   tuner_seq_ctrl_if #(.DAC_WIDTH(DW), .ADC_WIDTH(AW), .NUM_TARGET(NT)) bus ();

   tuner_seq_ctrl #(
      .DAC_WIDTH(DW), .ADC_WIDTH(AW), .NUM_TARGET(NT), .TMO_WIDTH(TW)
   ) dut (
      .i_clk                (clk),
      .i_rst_n              (rst_n),
      .i_en                 (en),
      .i_cfg_target_idx     (idx),
      .i_cfg_max_relock     (max_relock),
      .i_cfg_search_tmo     (tmo),
      .bus                  (bus),
      .o_cfg_ring_tune_peak (tune_out),
      .o_cfg_pwr_peak       (pwr_out),
      .o_state              (st),
      .o_locked             (locked),
      .o_err                (err),
      .o_relock_cnt         (relock),
      .o_search_cnt         (scnt)
   );

   int checks = 0;
   int failures = 0;
   int m_search = 0;
   logic [DW-1:0] tune_m [NT];
   logic [AW-1:0] pwr_m [NT];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic dut_sig(input int ch);
      case (ch)
         0:       return bus.o_search_trig_val;
         1:       return bus.o_search_done_rdy;
         2:       return bus.o_lock_trig_val;
         3:       return bus.o_lock_intr_rdy;
         default: return bus.o_lock_resume_val;
      endcase
   endfunction

   task automatic set_bench(input int ch, input logic v);
      case (ch)
         0:       bus.i_search_trig_rdy = v;
         1:       bus.i_search_done_val = v;
         2:       bus.i_lock_trig_rdy   = v;
         3:       bus.i_lock_intr_val   = v;
         default: bus.i_lock_resume_rdy = v;
      endcase
   endtask

   function automatic logic [38:0] snap();
      return {st, bus.o_search_trig_val, bus.o_search_done_rdy,
              bus.o_lock_trig_val, bus.o_lock_intr_rdy,
              bus.o_lock_resume_val, locked, err, relock, scnt,
              tune_out, pwr_out};
   endfunction

   // wait (bounded) for the DUT side of channel ch, then transfer once
   task automatic hs(input int ch, input int dly, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 64; i++) begin
         if (dut_sig(ch)) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (!ok) return;
      repeat (dly) tick();
      set_bench(ch, 1'b1);
      tick();
      set_bench(ch, 1'b0);
   endtask

   task automatic load_peaks(input int num);
      for (int i = 0; i < NT; i++) begin
         bus.i_peak_tune_codes[i] = tune_m[i];
         bus.i_peak_pwr_codes[i]  = pwr_m[i];
      end
      bus.i_num_peaks = 4'(num);
   endtask

   task automatic rand_peaks();
      for (int i = 0; i < NT; i++) begin
         tune_m[i] = DW'($urandom);
         pwr_m[i]  = AW'($urandom);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      en = 1'b0;
      for (int ch = 0; ch < 5; ch++) set_bench(ch, 1'b0);
      tick();
      rst_n = 1'b1;
      m_search = 0;
   endtask

   task automatic test_reset();
      logic [38:0] v;
      do_reset();
      rst_n = 1'b0;
      tick();
      v = snap();
      checks++;
      if (v !== '0)
         $display("FAIL reset_state: got %h want 0", v);
      rst_n = 1'b1;
   endtask

   task automatic test_basic_lock();
      do_reset();
      rand_peaks();
      tune_m[0] = 8'd40;
      tune_m[1] = 8'd90;
      tune_m[2] = 8'd200;
      load_peaks(3);
      idx = 3'd1;
      tmo = '0;
      max_relock = 4'd2;
      en = 1'b1;
      tick();
      checks++;
      if (bus.o_search_trig_val !== 1'b1 || st !== 3'd1) begin
         failures++;
         $display("FAIL trig_latency: got val=%b st=%0d want 1/1",
                  bus.o_search_trig_val, st);
      end
      bus.i_search_trig_rdy = 1'b1;
      tick();
      bus.i_search_trig_rdy = 1'b0;
      checks++;
      if (st !== 3'd2 || bus.o_search_done_rdy !== 1'b1 || scnt !== 8'd1) begin
         failures++;
         $display("FAIL search_xfer: got st=%0d rdy=%b cnt=%0d want 2/1/1",
                  st, bus.o_search_done_rdy, scnt);
      end
      bus.i_search_done_val = 1'b1;
      tick();
      bus.i_search_done_val = 1'b0;
      checks++;
      if (st !== 3'd3 || bus.o_lock_trig_val !== 1'b0) begin
         failures++;
         $display("FAIL select_cycle: got st=%0d lval=%b want 3/0",
                  st, bus.o_lock_trig_val);
      end
      tick();
      checks++;
      if (bus.o_lock_trig_val !== 1'b1 || tune_out !== 8'd90 ||
          pwr_out !== pwr_m[1]) begin
         failures++;
         $display("FAIL lock_cfg: got val=%b tune=%0d pwr=%0d want 1/90/%0d",
                  bus.o_lock_trig_val, tune_out, pwr_out, pwr_m[1]);
      end
      bus.i_lock_trig_rdy = 1'b1;
      tick();
      bus.i_lock_trig_rdy = 1'b0;
      checks++;
      if (locked !== 1'b1 || bus.o_lock_intr_rdy !== 1'b1 || st !== 3'd5) begin
         failures++;
         $display("FAIL locked: got locked=%b irdy=%b st=%0d want 1/1/5",
                  locked, bus.o_lock_intr_rdy, st);
      end
   endtask

   task automatic test_no_peaks();
      bit ok0, ok1;
      do_reset();
      rand_peaks();
      load_peaks(0);
      idx = 3'd0;
      tmo = '0;
      en = 1'b1;
      hs(0, 0, ok0);
      hs(1, 0, ok1);
      tick();
      checks++;
      if (!ok0 || !ok1 || st !== 3'd7 || err !== 2'd1) begin
         failures++;
         $display("FAIL no_peaks: got st=%0d err=%0d hs=%b%b want 7/1/11",
                  st, err, ok0, ok1);
      end
      en = 1'b0;
      tick();
      checks++;
      if (st !== 3'd0 || err !== 2'd0) begin
         failures++;
         $display("FAIL err_clear: got st=%0d err=%0d want 0/0", st, err);
      end
      en = 1'b1;
      hs(0, 0, ok0);
      checks++;
      if (!ok0 || scnt !== 8'd2) begin
         failures++;
         $display("FAIL search_cnt2: got cnt=%0d hs=%b want 2/1", scnt, ok0);
      end
   endtask

   task automatic test_idx_range();
      bit ok0, ok1, seen;
      do_reset();
      rand_peaks();
      load_peaks(3);
      idx = 3'd5;
      tmo = '0;
      en = 1'b1;
      hs(0, 0, ok0);
      hs(1, 0, ok1);
      seen = 1'b0;
      repeat (10) begin
         if (bus.o_lock_trig_val) seen = 1'b1;
         tick();
      end
      checks++;
      if (!ok0 || !ok1 || seen || st !== 3'd7 || err !== 2'd2) begin
         failures++;
         $display("FAIL idx_range: got st=%0d err=%0d ltrig=%b want 7/2/0",
                  st, err, seen);
      end
   endtask

   task automatic test_random_select(input int n);
      bit ok0, ok1;
      int num;
      logic [1:0] exp_err;
      for (int t = 0; t < n; t++) begin
         do_reset();
         rand_peaks();
         num = $urandom_range(0, NT);
         idx = 3'($urandom_range(0, NT - 1));
         load_peaks(num);
         tmo = '0;
         en = 1'b1;
         hs(0, $urandom_range(0, 3), ok0);
         hs(1, $urandom_range(0, 3), ok1);
         tick();
         if (num == 0)          exp_err = 2'd1;
         else if (int'(idx) >= num) exp_err = 2'd2;
         else                   exp_err = 2'd0;
         checks++;
         if (exp_err == 2'd0) begin
            if (!ok0 || !ok1 || st !== 3'd4 || tune_out !== tune_m[idx] ||
                pwr_out !== pwr_m[idx]) begin
               failures++;
               $display("FAIL rand_sel: num=%0d idx=%0d got st=%0d tune=%0d pwr=%0d want 4/%0d/%0d",
                        num, idx, st, tune_out, pwr_out, tune_m[idx], pwr_m[idx]);
            end
         end else if (!ok0 || !ok1 || st !== 3'd7 || err !== exp_err) begin
            failures++;
            $display("FAIL rand_err: num=%0d idx=%0d got st=%0d err=%0d want 7/%0d",
                     num, idx, st, err, exp_err);
         end
      end
   endtask

   task automatic test_relock(input logic [3:0] mr, input int n);
      bit ok;
      int num;
      int m_relock;
      logic [2:0] exp_st;
      do_reset();
      rand_peaks();
      num = $urandom_range(1, NT);
      idx = 3'($urandom_range(0, num - 1));
      load_peaks(num);
      max_relock = mr;
      tmo = '0;
      en = 1'b1;
      hs(0, 0, ok);
      hs(1, 0, ok);
      hs(2, 0, ok);
      m_search = 1;
      m_relock = 0;
      for (int i = 0; i < n; i++) begin
         hs(3, $urandom_range(0, 2), ok);
         if (m_relock < int'(mr)) begin
            m_relock++;
            exp_st = 3'd6;
         end else begin
            m_relock = 0;
            exp_st = 3'd1;
         end
         checks++;
         if (!ok || st !== exp_st || relock !== 4'(m_relock) ||
             locked !== 1'b0 || tune_out !== tune_m[idx]) begin
            failures++;
            $display("FAIL relock_intr%0d: mr=%0d got st=%0d cnt=%0d lk=%b tune=%0d want %0d/%0d/0/%0d",
                     i, mr, st, relock, locked, tune_out, exp_st, m_relock,
                     tune_m[idx]);
         end
         if (exp_st == 3'd6) begin
            hs(4, $urandom_range(0, 3), ok);
         end else begin
            hs(0, $urandom_range(0, 3), ok);
            if (m_search < 255) m_search++;
            checks++;
            if (!ok || scnt !== 8'(m_search)) begin
               failures++;
               $display("FAIL research_cnt: got %0d want %0d", scnt, m_search);
            end
            hs(1, $urandom_range(0, 3), ok);
            hs(2, $urandom_range(0, 3), ok);
         end
         checks++;
         if (!ok || locked !== 1'b1) begin
            failures++;
            $display("FAIL relock_back%0d: got locked=%b hs=%b want 1/1",
                     i, locked, ok);
         end
      end
   endtask

   task automatic test_timeout();
      bit ok;
      int cnt;
      bit left;
      do_reset();
      rand_peaks();
      load_peaks(3);
      idx = 3'd0;
      tmo = 16'd10;
      en = 1'b1;
      hs(0, 0, ok);
      cnt = 0;
      for (int i = 0; i < 50 && st == 3'd2; i++) begin
         cnt++;
         tick();
      end
      checks++;
      if (!ok || cnt != 10 || st !== 3'd7 || err !== 2'd3) begin
         failures++;
         $display("FAIL timeout: got wait=%0d st=%0d err=%0d want 10/7/3",
                  cnt, st, err);
      end
      en = 1'b0;
      tick();
      tmo = '0;
      en = 1'b1;
      hs(0, 0, ok);
      left = 1'b0;
      repeat (300) begin
         if (st !== 3'd2) left = 1'b1;
         tick();
      end
      checks++;
      if (!ok || left) begin
         failures++;
         $display("FAIL tmo_disabled: got left_wait=%b hs=%b want 0/1",
                  left, ok);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      rand_peaks();
      load_peaks(3);
      idx = 3'd0;
      tmo = '0;
      max_relock = 4'd1;
      en = 1'b1;
      for (int k = 0; k < 3; k++) begin
         int ch;
         bit ok, stable;
         logic [2:0] exp_st;
         ch = (k == 0) ? 0 : ((k == 1) ? 2 : 4);
         exp_st = (k == 0) ? 3'd2 : 3'd5;
         ok = 1'b1;
         if (k == 1) hs(1, 0, ok);
         if (k == 2) hs(3, 0, ok);
         for (int i = 0; i < 64 && !dut_sig(ch); i++) tick();
         if (!dut_sig(ch)) ok = 1'b0;
         stable = 1'b1;
         repeat (5) begin
            tick();
            if (dut_sig(ch) !== 1'b1) stable = 1'b0;
         end
         set_bench(ch, 1'b1);
         tick();
         set_bench(ch, 1'b0);
         checks++;
         if (!ok || !stable || dut_sig(ch) !== 1'b0 || st !== exp_st) begin
            failures++;
            $display("FAIL bp_ch%0d: got stable=%b val=%b st=%0d want 1/0/%0d",
                     ch, stable, dut_sig(ch), st, exp_st);
         end
      end
      checks++;
      if (scnt !== 8'd1) begin
         failures++;
         $display("FAIL bp_single: got cnt=%0d want 1", scnt);
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      do_reset();
      rand_peaks();
      load_peaks(1);
      idx = 3'd0;
      tmo = '0;
      max_relock = 4'd1;
      en = 1'b1;
      hs(0, 0, ok);
      hs(1, 0, ok);
      for (int i = 0; i < 64 && !bus.o_lock_trig_val; i++) tick();
      bus.i_lock_trig_rdy = 1'b1;
      bus.i_lock_intr_val = 1'b1;
      tick();
      bus.i_lock_trig_rdy = 1'b0;
      checks++;
      if (st !== 3'd5 || locked !== 1'b1) begin
         failures++;
         $display("FAIL b2b_locked: got st=%0d lk=%b want 5/1", st, locked);
      end
      tick();
      bus.i_lock_intr_val = 1'b0;
      checks++;
      if (st !== 3'd6 || relock !== 4'd1 || bus.o_lock_resume_val !== 1'b1) begin
         failures++;
         $display("FAIL b2b_intr: got st=%0d cnt=%0d rval=%b want 6/1/1",
                  st, relock, bus.o_lock_resume_val);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      logic [38:0] v;
      do_reset();
      rand_peaks();
      load_peaks(2);
      idx = 3'd0;
      tmo = '0;
      en = 1'b1;
      hs(0, 0, ok);
      hs(1, 0, ok);
      tick();
      checks++;
      if (st !== 3'd4 || bus.o_lock_trig_val !== 1'b1) begin
         failures++;
         $display("FAIL mid_ltrig: got st=%0d val=%b want 4/1",
                  st, bus.o_lock_trig_val);
      end
      rst_n = 1'b0;
      tick();
      v = snap();
      checks++;
      if (v !== '0) begin
         failures++;
         $display("FAIL reset_mid: got %h want 0", v);
      end
      rst_n = 1'b1;
      en = 1'b0;
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         checks++;
         if ($countones({bus.o_search_trig_val, bus.o_search_done_rdy,
                         bus.o_lock_trig_val, bus.o_lock_intr_rdy,
                         bus.o_lock_resume_val}) > 1) begin
            failures++;
            $display("FAIL onehot: got st=%0d with several val/rdy high, want at most one",
                     st);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      en = 1'b0;
      idx = '0;
      max_relock = '0;
      tmo = '0;
      for (int ch = 0; ch < 5; ch++) set_bench(ch, 1'b0);
      for (int i = 0; i < NT; i++) begin
         tune_m[i] = '0;
         pwr_m[i] = '0;
      end
      load_peaks(0);
      test_reset();
      test_basic_lock();
      test_no_peaks();
      test_idx_range();
      test_random_select(12);
      test_relock(4'd2, 4);
      test_relock(4'd0, 3);
      for (int r = 0; r < 4; r++)
         test_relock(4'($urandom_range(0, 3)), $urandom_range(5, 9));
      test_timeout();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
